serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial N-bit adder: the inverse operation of the team's subtractor
//   blocks (D + B recovers A). One full-adder slice plus a carry flop processes
//   operands LSB-first, one bit per clock.
//   It sits beside the subtractor datapath as the add/reconstruct path and is
//   the reference model for checking subtraction results (A - B + B == A).
// PARAMETERS
//   WIDTH  8  operand and sum width in bits (>= 2)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   start     in   1      request; sampled only in IDLE
//   a         in   WIDTH  augend, captured on accepted start
//   b         in   WIDTH  addend, captured on accepted start
//   cin       in   1      carry-in, captured on accepted start
//   busy      out  1      high while in SHIFT
//   done      out  1      one-cycle pulse: sum/cout/overflow are valid
//   sum       out  WIDTH  result, held until next accepted start
//   cout      out  1      final carry-out, held like sum
//   overflow  out  1      signed overflow (carry into MSB ^ carry out), held
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0,
//     overflow=0, bit counter=0, shift regs=0. Reset wins over every other
//     input and aborts an operation in progress; no done pulse follows.
//   FSM: IDLE -> SHIFT on start=1 at an edge.
//     Capture a, b into shift regs; carry <= cin; cnt <= 0; sum reg cleared.
//   SHIFT, every edge:
//     s = a_sr[0]^b_sr[0]^carry
//     carry <= majority(a_sr[0], b_sr[0], carry)
//     sum_sr <= {s, sum_sr[WIDTH-1:1]}; a_sr, b_sr shift right; cnt++.
//     On the edge with cnt==WIDTH-1 (the MSB bit):
//       overflow <= carry ^ majority(...); cout <= majority(...);
//       state -> DONE.
//   DONE: done=1 for exactly this one cycle; next edge -> IDLE
//     unconditionally.
//   Latency: start sampled at edge k -> busy=1 after edges k..k+WIDTH-1;
//     done=1 after edge k+WIDTH (WIDTH+1 cycles start-to-done).
//     Throughput: one add per WIDTH+2 cycles.
//   start while SHIFT or DONE: ignored. No queuing; a, b, cin are not
//     re-sampled.
//   sum/cout/overflow change only at an accepted start (cleared) and during
//     SHIFT; stable in DONE and IDLE until next start.
//   Arithmetic is modulo 2^WIDTH: {cout,sum} == a + b + cin exactly.
//   busy and done are never high together; both are 0 in IDLE.
// TESTING
//   1. a=8'h3C, b=8'h5A, cin=0 -> done after 9 cycles; sum=8'h96, cout=0,
//        overflow=1.
//   2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0;
//        a=8'h80, b=8'h80 -> sum=8'h00, cout=1, overflow=1.
//   3. a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0;
//        a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//   4. start pulsed again 3 cycles after an accepted start with different
//        operands -> ignored; first result delivered; single done pulse.
//   5. rst=1 four cycles into SHIFT -> next cycle busy=0, sum=0, no done;
//        new start after reset -> correct result.
//   6. Exhaustive, WIDTH=3: for all a, b in 0..7, D=(a-b) mod 8;
//        add D+b, cin=0 -> sum==a every case.
//        Back-to-back starts issued the cycle after done returns to IDLE.

Source files
------------

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between a serial_adder and its user
//
// Purpose: groups the start/operand request and the busy/done/result response
//   of one bit-serial adder so both ends share a single typed connection.
// Signals:
//   start     request, sampled by the adder only while idle
//   a, b      WIDTH-bit operands, captured on an accepted start
//   cin       carry-in, captured on an accepted start
//   busy      adder is shifting
//   done      one-cycle pulse, result fields valid
//   sum       WIDTH-bit result, held until the next accepted start
//   cout      final carry-out, held like sum
//   overflow  signed overflow of the addition, held like sum
// Modports: master drives the request and reads the result; slave is the adder.

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder slice, LSB first
//
// Purpose: computes {cout, sum} = a + b + cin one bit per clock using a single
//   full-adder slice and a carry flop; also reports signed overflow. Serves as
//   the add/reconstruct path next to the subtractor datapath (A - B + B == A).
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; aborts any operation, no done follows
//   bus   serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout/overflow out
// Timing: start accepted at edge k -> busy after edges k..k+WIDTH-1, done for
//   one cycle after edge k+WIDTH, back to idle at the next edge regardless of
//   start. One addition per WIDTH+2 cycles at best.

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt;

  logic busy;
  logic done;
  logic accept;
  logic last_bit;
  logic bit_s;
  logic bit_c;

  // Full-adder slice on the current LSBs of the operand shift registers.
  assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit = (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operands shift out LSB first, sum bits enter at the MSB so that
  // after WIDTH shifts sum_sr holds the result in natural bit order.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      sum_sr <= '0;
      carry  <= bus.cin;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
      carry  <= bit_c;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        // On the MSB slice, carry holds the carry into the MSB; signed
        // overflow is that carry differing from the carry out.
        cout_r <= bit_c;
        ovf_r  <= carry ^ bit_c;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.sum      = sum_sr;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=3)

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(3)) bus3 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 addition against the arithmetic reference, with latency,
  // busy/done exclusivity and post-done hold checks.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input string tag);
    logic [8:0] full;
    logic [7:0] es;
    logic       ec;
    logic       eo;
    int         n;
    full = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    es   = full[7:0];
    ec   = full[8];
    eo   = (av[7] == bv[7]) && (es[7] != av[7]);
    bus8.a = av; bus8.b = bv; bus8.cin = cv; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    n = 0;
    while (!bus8.done && n < 40) begin
      check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_done_nobusy"}, 32'(bus8.busy), 32'd0);
    check({tag, "_sum"}, 32'(bus8.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
    check({tag, "_ovf"}, 32'(bus8.overflow), 32'(eo));
    step();
    check({tag, "_idle_done"}, 32'(bus8.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus8.busy), 32'd0);
    check({tag, "_hold_sum"}, 32'(bus8.sum), 32'(es));
  endtask

  task automatic run3(input logic [2:0] av, input logic [2:0] bv, input logic [2:0] expect_sum, input string tag);
    int n;
    bus3.a = av; bus3.b = bv; bus3.cin = 1'b0; bus3.start = 1'b1;
    step();
    bus3.start = 1'b0;
    n = 0;
    while (!bus3.done && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_sum"}, 32'(bus3.sum), 32'(expect_sum));
    step();
  endtask

  initial begin
    int          n;
    int          dcount;
    logic [2:0]  d3;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_sum", 32'(bus8.sum), 32'd0);
    check("rst_cout", 32'(bus8.cout), 32'd0);
    check("rst_ovf", 32'(bus8.overflow), 32'd0);

    run8(8'h3C, 8'h5A, 1'b0, "t1");
    check("t1_const_sum", 32'(bus8.sum), 32'h96);
    check("t1_const_ovf", 32'(bus8.overflow), 32'd1);
    run8(8'hFF, 8'h01, 1'b0, "t2a");
    run8(8'h80, 8'h80, 1'b0, "t2b");
    check("t2b_const_ovf", 32'(bus8.overflow), 32'd1);
    run8(8'h00, 8'h00, 1'b1, "t3a");
    check("t3a_const_sum", 32'(bus8.sum), 32'h01);
    run8(8'hFF, 8'hFF, 1'b1, "t3b");
    check("t3b_const_cout", 32'(bus8.cout), 32'd1);

    // Start pulsed mid-operation with other operands must be ignored.
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step(); step(); step();
    bus8.a = 8'hAA; bus8.b = 8'h77; bus8.cin = 1'b1; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    n = 4;
    while (!bus8.done && n < 40) begin
      step();
      n++;
    end
    check("t4_lat", 32'(n), 32'd8);
    check("t4_sum", 32'(bus8.sum), 32'h46);
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus8.done) dcount++;
    end
    check("t4_single_done", 32'(dcount), 32'd0);
    check("t4_hold_sum", 32'(bus8.sum), 32'h46);

    // Reset four cycles into SHIFT aborts without a done pulse.
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b0; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step(); step(); step(); step();
    check("t5_pre_busy", 32'(bus8.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", 32'(bus8.busy), 32'd0);
    check("t5_sum", 32'(bus8.sum), 32'd0);
    check("t5_done", 32'(bus8.done), 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus8.done) dcount++;
    end
    check("t5_no_done", 32'(dcount), 32'd0);
    run8(8'h5A, 8'hA5, 1'b1, "t5_after");

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 25; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    // WIDTH=3: (a - b) + b recovers a for every operand pair, back to back.
    for (int av = 0; av < 8; av++) begin
      for (int bv = 0; bv < 8; bv++) begin
        d3 = 3'(av - bv);
        run3(d3, 3'(bv), 3'(av), $sformatf("w3_%0d_%0d", av, bv));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
